// File: rtl/serdes_pkg.sv
// Shared types and constants for the 9-bit K/data symbol serdes pair.
package serdes_pkg;

  localparam int unsigned SYM_W      = 9;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FRAME_SYMS = 3;
  localparam int unsigned FRAME_W    = SYM_W * FRAME_SYMS;
  localparam int unsigned BCNT_W     = 4;
  localparam int unsigned IDX_W      = 2;

  localparam logic [BYTE_W-1:0] COMMA = 8'h3C;
  localparam logic              KCODE = 1'b1;

  typedef struct packed {
    logic              k;
    logic [BYTE_W-1:0] data;
  } sym_t;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_IDLE,
    ST_FRAME
  } state_t;

  // True for the alignment comma {K=1, 8'h3C}
  function automatic logic is_comma(input sym_t s);
    return (s.k == KCODE) && (s.data == COMMA);
  endfunction

endpackage

// File: rtl/rx_serial.sv
// Serial-to-symbol front end: LSB-first shift register plus 0..8 bit counter.
// sym_o is the window including the bit currently presented, so the FSM can
// act on a completed symbol in the same cycle that its last bit is consumed.
module rx_serial
  import serdes_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             bit_vld_i,
  input  logic             realign_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_stb_o
);

  logic [SYM_W-1:0]  r_sr;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [SYM_W-1:0]  w_sr_nxt;
  logic              w_last;

  assign w_sr_nxt  = {bit_i, r_sr[SYM_W-1:1]};
  assign w_last    = (r_bit_cnt == BCNT_W'(SYM_W - 1));
  assign sym_o     = w_sr_nxt;
  assign sym_stb_o = bit_vld_i && w_last;

  // Shift in qualified bits; realign restarts the symbol count at a boundary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else if (bit_vld_i) begin
      r_sr <= w_sr_nxt;
      if (realign_i || w_last) r_bit_cnt <= '0;
      else                     r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/deserializer.sv
// Symbol deserializer: comma-based alignment, lock tracking and 3-symbol
// frame reassembly into a 27-bit word with registered strobes.
module deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned LOSS_CNT = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               bit_i,
  input  logic               bit_vld_i,
  output logic [FRAME_W-1:0] data_o,
  output logic               valid_o,
  output logic               locked_o,
  output logic               frame_err_o
);

  localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned LSS_W = $clog2(LOSS_CNT + 1);

  logic [SYM_W-1:0] w_sym_raw;
  logic             w_sym_stb;
  logic             w_realign;
  sym_t             w_sym;
  logic             w_comma;

  state_t             r_state,     w_state_nxt;
  logic [LCK_W-1:0]   r_lock_cnt,  w_lock_cnt_nxt;
  logic [LSS_W-1:0]   r_loss_cnt,  w_loss_cnt_nxt;
  logic [IDX_W-1:0]   r_word_idx,  w_word_idx_nxt;
  logic [SYM_W-1:0]   r_sym0,      w_sym0_nxt;
  logic [SYM_W-1:0]   r_sym1,      w_sym1_nxt;
  logic [FRAME_W-1:0] r_data,      w_data_nxt;
  logic               r_valid,     w_valid_nxt;
  logic               r_locked,    w_locked_nxt;
  logic               r_frame_err, w_frame_err_nxt;

  rx_serial u_rx_serial (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .bit_i     (bit_i),
    .bit_vld_i (bit_vld_i),
    .realign_i (w_realign),
    .sym_o     (w_sym_raw),
    .sym_stb_o (w_sym_stb)
  );

  assign w_sym   = sym_t'(w_sym_raw);
  assign w_comma = is_comma(w_sym);

  // Lock/frame next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_loss_cnt_nxt  = r_loss_cnt;
    w_word_idx_nxt  = r_word_idx;
    w_sym0_nxt      = r_sym0;
    w_sym1_nxt      = r_sym1;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_locked_nxt    = r_locked;
    w_realign       = 1'b0;

    unique case (r_state)
      ST_HUNT: begin
        if (bit_vld_i && w_comma) begin
          w_realign      = 1'b1;
          w_lock_cnt_nxt = LCK_W'(1);
          w_state_nxt    = ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        if (w_sym_stb) begin
          if (w_comma) begin
            if (32'(r_lock_cnt) + 32'd1 >= LOCK_CNT) begin
              w_lock_cnt_nxt = '0;
              w_loss_cnt_nxt = '0;
              w_locked_nxt   = 1'b1;
              w_state_nxt    = ST_IDLE;
            end else begin
              w_lock_cnt_nxt = r_lock_cnt + LCK_W'(1);
            end
          end else begin
            w_lock_cnt_nxt = '0;
            w_state_nxt    = ST_HUNT;
          end
        end
      end

      ST_IDLE, ST_FRAME: begin
        if (w_sym_stb) begin
          if (w_sym.k != KCODE) begin
            if (r_state == ST_IDLE) begin
              w_sym0_nxt     = w_sym_raw;
              w_word_idx_nxt = IDX_W'(1);
              w_state_nxt    = ST_FRAME;
            end else if (r_word_idx == IDX_W'(FRAME_SYMS - 1)) begin
              w_data_nxt     = {w_sym_raw, r_sym1, r_sym0};
              w_valid_nxt    = 1'b1;
              w_word_idx_nxt = '0;
              w_state_nxt    = ST_IDLE;
            end else begin
              w_sym1_nxt     = w_sym_raw;
              w_word_idx_nxt = r_word_idx + IDX_W'(1);
            end
          end else begin
            // K symbol: aborts any partial frame, then lock-health bookkeeping
            w_frame_err_nxt = (r_state == ST_FRAME);
            w_word_idx_nxt  = '0;
            w_state_nxt     = ST_IDLE;
            if (w_comma) begin
              w_loss_cnt_nxt = '0;
            end else if (32'(r_loss_cnt) + 32'd1 >= LOSS_CNT) begin
              w_loss_cnt_nxt = '0;
              w_locked_nxt   = 1'b0;
              w_state_nxt    = ST_HUNT;
            end else begin
              w_loss_cnt_nxt = r_loss_cnt + LSS_W'(1);
            end
          end
        end
      end

      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_HUNT;
      r_lock_cnt  <= '0;
      r_loss_cnt  <= '0;
      r_word_idx  <= '0;
      r_sym0      <= '0;
      r_sym1      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_loss_cnt  <= w_loss_cnt_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_sym0      <= w_sym0_nxt;
      r_sym1      <= w_sym1_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign locked_o    = r_locked;
  assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the symbol deserializer: table of symbols with expected
// outputs, plus hand-written gated-input and mid-frame reset sequences.
module tb_deserializer;

  logic        clk;
  logic        rst_ni;
  logic        bit_i;
  logic        bit_vld_i;
  logic [26:0] data_o;
  logic        valid_o;
  logic        locked_o;
  logic        frame_err_o;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;

  typedef struct packed {
    logic [2:0]  pre;
    logic [8:0]  sym;
    logic        ev;
    logic        ee;
    logic        el;
    logic [26:0] ed;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vec [NVEC];

  deserializer #(.LOCK_CNT(2), .LOSS_CNT(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bit_i       (bit_i),
    .bit_vld_i   (bit_vld_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .locked_o    (locked_o),
    .frame_err_o (frame_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (valid_o) n_valid++;
    if (frame_err_o) n_err++;
    if (valid_o && frame_err_o) n_both++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: inputs set at negedge, consumed at posedge, return #1 after it
  task automatic drive_bit(input logic b, input logic v);
    @(negedge clk);
    bit_i     = b;
    bit_vld_i = v;
    @(posedge clk);
    #1;
    bit_vld_i = 1'b0;
  endtask

  task automatic send_sym(input logic [8:0] s, input bit gated);
    for (int i = 0; i < 9; i++) begin
      if (gated) begin
        for (int g = 0; g < 6; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          drive_bit(1'($urandom_range(0, 1)), 1'b0);
        end
      end
      drive_bit(s[i], 1'b1);
    end
  endtask

  task automatic send_garbage(input int n);
    logic [3:0] g;
    // never all ones: that prefix plus a comma's head looks like a comma
    g = 4'($urandom_range(0, (1 << n) - 2));
    for (int i = 0; i < n; i++) drive_bit(g[i], 1'b1);
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic e,
                          input logic l, input logic [26:0] d);
    chk({tag, ".valid"},  32'(valid_o),     32'(v));
    chk({tag, ".err"},    32'(frame_err_o), 32'(e));
    chk({tag, ".locked"}, 32'(locked_o),    32'(l));
    chk({tag, ".data"},   32'(data_o),      32'(d));
  endtask

  initial begin
    vec[0]  = '{3'd4, 9'h13C, 1'b0, 1'b0, 1'b0, 27'h0};
    vec[1]  = '{3'd0, 9'h13C, 1'b0, 1'b0, 1'b1, 27'h0};
    vec[2]  = '{3'd0, 9'h13C, 1'b0, 1'b0, 1'b1, 27'h0};
    vec[3]  = '{3'd0, 9'h0A5, 1'b0, 1'b0, 1'b1, 27'h0};
    vec[4]  = '{3'd0, 9'h05A, 1'b0, 1'b0, 1'b1, 27'h0};
    vec[5]  = '{3'd0, 9'h0FF, 1'b1, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[6]  = '{3'd0, 9'h13C, 1'b0, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[7]  = '{3'd0, 9'h011, 1'b0, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[8]  = '{3'd0, 9'h13C, 1'b0, 1'b1, 1'b1, 27'h3FCB4A5};
    vec[9]  = '{3'd0, 9'h1F7, 1'b0, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[10] = '{3'd0, 9'h1F7, 1'b0, 1'b0, 1'b0, 27'h3FCB4A5};
    vec[11] = '{3'd3, 9'h13C, 1'b0, 1'b0, 1'b0, 27'h3FCB4A5};
    vec[12] = '{3'd0, 9'h13C, 1'b0, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[13] = '{3'd0, 9'h012, 1'b0, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[14] = '{3'd0, 9'h034, 1'b0, 1'b0, 1'b1, 27'h3FCB4A5};
    vec[15] = '{3'd0, 9'h056, 1'b1, 1'b0, 1'b1, 27'h1586812};
    vec[16] = '{3'd0, 9'h13C, 1'b0, 1'b0, 1'b1, 27'h1586812};

    rst_ni    = 1'b0;
    bit_i     = 1'b0;
    bit_vld_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 27'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Lock, frame, abort, lock loss and relock at a shifted offset
    for (int i = 0; i < NVEC; i++) begin
      if (vec[i].pre != 0) send_garbage(int'(vec[i].pre));
      send_sym(vec[i].sym, 1'b0);
      chk_outs($sformatf("vec%0d", i), vec[i].ev, vec[i].ee, vec[i].el, vec[i].ed);
    end

    // Gated input: valid follows the last qualified bit
    send_sym(9'h0A5, 1'b1);
    send_sym(9'h05A, 1'b1);
    chk("gated.pre_valid", 32'(valid_o), 32'd0);
    send_sym(9'h0FF, 1'b1);
    chk_outs("gated", 1'b1, 1'b0, 1'b1, 27'h3FCB4A5);
    drive_bit(1'b1, 1'b0);
    chk("gated.valid_drop", 32'(valid_o), 32'd0);
    chk("gated.data_hold", 32'(data_o), 32'h3FCB4A5);

    // Reset mid-frame, ignored unlocked frame, then relock
    send_sym(9'h13C, 1'b0);
    send_sym(9'h0A5, 1'b0);
    send_sym(9'h05A, 1'b0);
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 27'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    send_sym(9'h0A5, 1'b0);
    send_sym(9'h05A, 1'b0);
    send_sym(9'h0FF, 1'b0);
    chk_outs("unlocked_frame", 1'b0, 1'b0, 1'b0, 27'h0);
    send_sym(9'h13C, 1'b0);
    chk("relock1.locked", 32'(locked_o), 32'd0);
    send_sym(9'h13C, 1'b0);
    chk("relock2.locked", 32'(locked_o), 32'd1);
    send_sym(9'h0A5, 1'b0);
    send_sym(9'h05A, 1'b0);
    send_sym(9'h0FF, 1'b0);
    chk_outs("relock_frame", 1'b1, 1'b0, 1'b1, 27'h3FCB4A5);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);

    chk("valid_pulses", 32'(n_valid), 32'd4);
    chk("err_pulses", 32'(n_err), 32'd1);
    chk("valid_err_overlap", 32'(n_both), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
